// File: rtl/rx_bit_timer.sv
// USB receive bit timer: recovers the mid-bit sample point from D+ edges,
// removes stuffed bits and marks byte boundaries for the receive shift register.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3,
    parameter int BITS_PER_BYTE = 8,
    parameter int STUFF_RUN     = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE);
    localparam int OW = $clog2(STUFF_RUN + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_PT = CW'(SAMPLE_OFFSET);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_BYTE - 1);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_RUN);

    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [OW-1:0] ones_cnt;
    logic          sample_p0;
    logic          stuff_p0;
    logic          last_bit_p0;

    // An edge marks phase 0 of a new bit, so the following cycle is phase 1.
    function automatic logic [CW-1:0] next_phase(input logic [CW-1:0] cnt,
                                                 input logic          resync);
        if (resync)
            return CW'(1);
        else if (cnt == CLK_LAST)
            return '0;
        else
            return cnt + CW'(1);
    endfunction

    // Stage p0: sample point decode; an edge landing on it suppresses the sample
    assign sample_p0   = rcving && !d_edge && (clk_cnt == SAMPLE_PT);
    assign stuff_p0    = (ones_cnt == ONES_MAX);
    assign last_bit_p0 = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (!rcving) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else begin
            clk_cnt <= next_phase(clk_cnt, d_edge);
            if (sample_p0) begin
                if (stuff_p0) begin
                    ones_cnt <= '0;
                end else begin
                    ones_cnt <= d_orig ? ones_cnt + OW'(1) : '0;
                    bit_cnt  <= last_bit_p0 ? '0 : bit_cnt + BW'(1);
                end
            end
        end
    end

    // Stage p1: registered one-cycle pulses; sample_p0 already folds in rcving
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
            stuff_err     <= 1'b0;
        end else begin
            shift_enable  <= sample_p0 && !stuff_p0;
            byte_received <= sample_p0 && !stuff_p0 && last_bit_p0;
            stuff_err     <= sample_p0 && stuff_p0 && d_orig;
        end
    end

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Timing and bit-unstuffing stage of the USB receive path. Sits directly downstream of the receive edge detector.
- Runs a per-bit sample counter that resynchronises on every d_edge pulse. Issues a one-cycle shift_enable at the mid-bit sample point for each data bit.
- Drops stuffed bits after six consecutive ones. Flags byte boundaries and stuffing violations for the receive controller and shift register.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time.
- SAMPLE_OFFSET, 3, clk_cnt value at which a bit is sampled (1..CLKS_PER_BIT-1).
- BITS_PER_BYTE, 8, data bits per byte_received pulse.
- STUFF_RUN, 6, consecutive sampled ones after which the next bit is a stuff bit.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- rcving  input  1  packet reception active; 0 holds block idle/cleared
- d_edge  input  1  one-cycle pulse from edge detector on any D+ transition
- d_orig  input  1  NRZI-decoded bit value, valid at the sample point
- shift_enable  output  1  one-cycle pulse: shift d_orig sample into RX shift register
- byte_received  output  1  one-cycle pulse coincident with shift_enable of the last bit of a byte
- stuff_err  output  1  one-cycle pulse: stuff bit sampled as 1

Behaviour:
- Reset n_rst, asynchronous, active-low; clock clk.
- Reset values: clk_cnt=0, bit_cnt=0, ones_cnt=0, shift_enable=0, byte_received=0, stuff_err=0.
- Counter widths: clk_cnt $clog2(CLKS_PER_BIT), bit_cnt $clog2(BITS_PER_BYTE), ones_cnt $clog2(STUFF_RUN+1).
- rcving=0:
  - Next edge synchronously clears all counters and outputs to reset values.
  - d_edge ignored.
- rcving=1, clk_cnt update each cycle:
  - If d_edge=1: clk_cnt <= 1. The edge cycle counts as phase 0.
  - Else if clk_cnt==CLKS_PER_BIT-1: clk_cnt <= 0.
  - Else: clk_cnt <= clk_cnt+1.
- Sample event: rcving=1 and clk_cnt==SAMPLE_OFFSET and d_edge=0.
  - d_edge coincident with the sample point suppresses the sample; phase resets.
- On sample event, if ones_cnt==STUFF_RUN (stuff bit):
  - No shift.
  - ones_cnt <= 0.
  - stuff_err <= d_orig.
  - bit_cnt unchanged.
- On sample event, otherwise (data bit):
  - shift_enable <= 1.
  - ones_cnt <= d_orig ? ones_cnt+1 : 0.
  - If bit_cnt==BITS_PER_BYTE-1: byte_received <= 1, bit_cnt <= 0.
  - Else: bit_cnt <= bit_cnt+1.
- All outputs are registered: they pulse in the cycle after the sample event, for exactly one cycle. Latency from sample-point cycle is 1 clk.
- Outputs are 0 in every cycle not following a qualifying sample event.
- Without edges (long runs of NRZI 1s) clk_cnt free-runs and wraps. One sample is taken per CLKS_PER_BIT cycles.
- Stuff-bit counting crosses byte boundaries: ones_cnt is not cleared by byte_received.
- rcving falling mid-byte: the partial bit_cnt/ones_cnt is discarded and no byte_received is issued. A pulse already registered completes its single cycle, then clears.
- Asynchronous reset mid-operation: all outputs 0 immediately. Operation restarts on the next rcving=1 with cleared counters.

Test Plan:
- Reset, then hold rcving=0 with random d_edge for 50 cycles -> all outputs 0, counters 0.
- rcving=1 at cycle 0, d_edge pulses at cycles 0,8,16,...,56, d_orig alternating 0/1:
  - shift_enable at cycles 4,12,20,...,60.
  - byte_received only at cycle 60.
  - stuff_err never.
- d_orig=1 held, edge only at cycle 0:
  - shift_enable at cycles 4,12,20,28,36,44.
  - No pulse at cycle 52 (stuff bit, d_orig=1) -> stuff_err at cycle 52.
  - shift_enable resumes at cycle 60.
- Same as previous but d_orig=0 during cycle 51 -> no shift and no stuff_err at 52; next shift at 60.
- Early/late edge: edges at 0 and 6, then every 8 -> shift_enable at 4, then 10, 18, 26 (resync phase). An edge at clk_cnt==3 suppresses that sample.
- Drop rcving at cycle 30 mid-byte, restart at cycle 40 with an edge -> first shift_enable at 44. byte_received occurs only after 8 new shifts.
